// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit_if : word-memory req/ack bus between unit and memory      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit : multicycle MIPS memory stage, IR/MDR + req/ack master   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              rd_req_i,
  input  wire logic              wr_req_i,
  input  wire logic              irwrite_i,
  input  wire logic [ADDR_W-1:0] adr_i,
  input  wire logic [DATA_W-1:0] wd_i,
  output logic      [DATA_W-1:0] instr_o,
  output logic      [DATA_W-1:0] data_o,
  output logic                   stall_o,
  output logic                   done_o,
  output logic                   bus_err_o,
  mem_access_unit_if.master      bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              req_q,     req_d;
  logic              we_q,      we_d;
  logic              irw_q,     irw_d;
  logic              err_q,     err_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] instr_q,   instr_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    irw_d   = irw_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_req_i || rd_req_i) begin
          // Write wins when both strobes are raised together.
          state_d = wr_req_i ? S_WR_WAIT : S_RD_WAIT;
          req_d   = 1'b1;
          we_d    = wr_req_i;
          irw_d   = irwrite_i;
          addr_d  = adr_i;
          wdata_d = wd_i;
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (state_q == S_RD_WAIT) begin
            if (irw_q) instr_d = bus.mem_rdata;
            else       data_d  = bus.mem_rdata;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = S_ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign instr_o   = instr_q;
  assign data_o    = data_q;
  assign bus_err_o = err_q;
  assign done_o    = (state_q == S_DONE);
  assign stall_o   = ((state_q == S_IDLE) && (rd_req_i || wr_req_i)) ||
                     (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Directed bench for mem_access_unit: vector table plus timeout and reset sequences.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, wr_req, irwrite;
  logic [AW-1:0] adr;
  logic [DW-1:0] wd;
  logic [DW-1:0] instr, data;
  logic          stall, done, bus_err;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req_i  (rd_req),
    .wr_req_i  (wr_req),
    .irwrite_i (irwrite),
    .adr_i     (adr),
    .wd_i      (wd),
    .instr_o   (instr),
    .data_o    (data),
    .stall_o   (stall),
    .done_o    (done),
    .bus_err_o (bus_err),
    .bus       (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        irw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] e_instr;
    logic [31:0] e_data;
    logic        e_we;
  } vec_t;

  vec_t vecs [5];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, reqn, stl;
    logic got;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h04, 32'h0,        32'h8C080010, 2, 32'h8C080010, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1, 32'h8C080010, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h44, 32'h12345678, 32'hFFFFFFFF, 1, 32'h8C080010, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 32'h11111111, 3, 32'h8C080010, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h07, 32'h0,        32'hA5A5A5A5, 3, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};

    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; irwrite = 1'b0;
    adr = '0; wd = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #1;
    chk("rst_instr",   instr, 32'h0);
    chk("rst_data",    data, 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'h0);
    chk("rst_addr",    bus.mem_addr, 32'h0);
    chk("rst_wdata",   bus.mem_wdata, 32'h0);
    chk("rst_done",    32'(done), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_stall",   32'(stall), 32'h0);
    #13 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd_req = vecs[i].rd; wr_req = vecs[i].wr; irwrite = vecs[i].irw;
      adr = vecs[i].adr; wd = vecs[i].wd;
      bus.mem_rdata = vecs[i].rdata; bus.mem_ack = 1'b0;
      #1 chk($sformatf("v%0d_stall_launch", i), 32'(stall), 32'h1);
      cyc = 0; reqn = 0; stl = 0; got = 1'b0;
      while (!got && cyc < 12) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          got = 1'b1;
          bus.mem_ack = 1'b0;
        end else begin
          if (stall) stl++;
          if (bus.mem_req) begin
            reqn++;
            if (reqn == 1) begin
              chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr, vecs[i].adr);
              chk($sformatf("v%0d_mem_we", i),    32'(bus.mem_we), 32'(vecs[i].e_we));
              chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wd);
            end
            bus.mem_ack = (reqn == vecs[i].delay);
          end else begin
            bus.mem_ack = 1'b0;
          end
        end
      end
      chk($sformatf("v%0d_done_seen", i),  32'(got), 32'h1);
      chk($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].delay + 1));
      chk($sformatf("v%0d_wait_stall", i), 32'(stl), 32'(vecs[i].delay));
      chk($sformatf("v%0d_instr", i),      instr, vecs[i].e_instr);
      chk($sformatf("v%0d_data", i),       data, vecs[i].e_data);
      chk($sformatf("v%0d_stall_done", i), 32'(stall), 32'h0);
      // Requests stay held through DONE; no second access may launch from it.
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_no_relaunch", i), 32'(bus.mem_req), 32'h0);
      rd_req = 1'b0; wr_req = 1'b0;
    end
    chk("table_bus_err", 32'(bus_err), 32'h0);

    @(negedge clk);
    rd_req = 1'b1; irwrite = 1'b0; adr = 32'h80;
    bus.mem_rdata = 32'h99; bus.mem_ack = 1'b0;
    reqn = 0; got = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      if (bus.mem_req) reqn++;
      if (done) got = 1'b1;
    end
    chk("to_wait_cycles", 32'(reqn), 32'(TO));
    @(negedge clk);
    chk("to_bus_err",  32'(bus_err), 32'h1);
    chk("to_mem_req",  32'(bus.mem_req), 32'h0);
    chk("to_stall",    32'(stall), 32'h0);
    if (done) got = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    if (done) got = 1'b1;
    chk("to_no_done",  32'(got), 32'h0);
    chk("to_sticky",   32'(bus_err), 32'h1);
    chk("to_data",     data, 32'hDEADBEEF);
    chk("to_instr",    instr, 32'hA5A5A5A5);

    @(negedge clk);
    rd_req = 1'b1; irwrite = 1'b1; adr = 32'hC0; bus.mem_rdata = 32'h77;
    @(negedge clk);
    chk("rs_req_before", 32'(bus.mem_req), 32'h1);
    #2 reset = 1'b1; rd_req = 1'b0;
    #1;
    chk("rs_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rs_instr",   instr, 32'h0);
    chk("rs_data",    data, 32'h0);
    chk("rs_addr",    bus.mem_addr, 32'h0);
    chk("rs_bus_err", 32'(bus_err), 32'h0);
    chk("rs_done",    32'(done), 32'h0);
    #1 reset = 1'b0; bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stale_instr",   instr, 32'h0);
    chk("stale_mem_req", 32'(bus.mem_req), 32'h0);
    chk("stale_done",    32'(done), 32'h0);
    chk("stale_stall",   32'(stall), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
